// File: rtl/sdram_burst_tester.sv
// Avalon-MM burst master that writes a seeded incrementing pattern to the SDRAM
// controller, reads it back and reports mismatches.
module sdram_burst_tester #(
   parameter int unsigned        ADDR_W     = 25,
   parameter int unsigned        DATA_W     = 16,
   parameter int unsigned        BE_W       = DATA_W / 8,
   parameter int unsigned        BURST_W    = 7,
   parameter int unsigned        BURST_LEN  = 8,
   parameter int unsigned        NUM_BURSTS = 4,
   parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
   parameter int unsigned        ERR_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [DATA_W-1:0]   seed,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ERR_W-1:0]    error_count,
   output logic [ADDR_W-1:0]   first_err_addr,
   output logic                protocol_err,
   output logic [ADDR_W-1:0]   dbus_address,
   output logic [DATA_W-1:0]   dbus_writedata,
   input  logic [DATA_W-1:0]   dbus_readdata,
   output logic [BE_W-1:0]     dbus_byteenable,
   output logic [BURST_W-1:0]  dbus_burstcount,
   output logic                dbus_read,
   output logic                dbus_write,
   input  logic                dbus_waitrequest,
   input  logic                dbus_readdatavalid
);

   localparam int unsigned K_W = $clog2(BURST_LEN + 1);
   localparam int unsigned B_W = $clog2(NUM_BURSTS + 1);
   localparam logic [K_W-1:0]    K_LAST      = K_W'(BURST_LEN - 1);
   localparam logic [B_W-1:0]    B_LAST      = B_W'(NUM_BURSTS - 1);
   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BE_W);
   localparam logic [ADDR_W-1:0] BEAT_BYTES  = ADDR_W'(BE_W);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_READ_CMD, S_READ_DATA, S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [B_W-1:0]      b_q, b_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [DATA_W-1:0]   seed_q, seed_d;
   logic [1:0]          mode_q, mode_d;
   logic [ERR_W-1:0]    err_q, err_d;
   logic [ADDR_W-1:0]   ferr_q, ferr_d;
   logic                pass_q, pass_d;
   logic                perr_q, perr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                wr_q, wr_d;
   logic                rd_q, rd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [BURST_W-1:0]  bc_q, bc_d;

   function automatic logic [ADDR_W-1:0] burst_addr(input logic [B_W-1:0] b);
      return BASE_ADDR + ADDR_W'(b) * BURST_BYTES;
   endfunction

   function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                 input logic [B_W-1:0]    b,
                                                 input logic [K_W-1:0]    k);
      return s + DATA_W'(b) * DATA_W'(BURST_LEN) + DATA_W'(k);
   endfunction

   // Sequencer plus next values of every registered output
   always_comb begin
      state_d = state_q;
      b_d     = b_q;
      k_d     = k_q;
      seed_d  = seed_q;
      mode_d  = mode_q;
      err_d   = err_q;
      ferr_d  = ferr_q;
      pass_d  = pass_q;
      perr_d  = perr_q | (dbus_readdatavalid && (state_q != S_READ_DATA));

      case (state_q)
         S_IDLE: begin
            if (start) begin
               seed_d  = seed;
               mode_d  = mode;
               err_d   = '0;
               ferr_d  = '0;
               pass_d  = 1'b0;
               b_d     = '0;
               k_d     = '0;
               state_d = (mode == 2'd2) ? S_READ_CMD : S_WRITE;
            end
         end
         S_WRITE: begin
            if (wr_q && !dbus_waitrequest) begin
               if (k_q == K_LAST) begin
                  k_d = '0;
                  if (b_q == B_LAST) begin
                     b_d     = '0;
                     state_d = (mode_q == 2'd1) ? S_DONE : S_READ_CMD;
                  end else begin
                     b_d = b_q + B_W'(1);
                  end
               end else begin
                  k_d = k_q + K_W'(1);
               end
            end
         end
         S_READ_CMD: begin
            if (rd_q && !dbus_waitrequest) begin
               k_d     = '0;
               state_d = S_READ_DATA;
            end
         end
         S_READ_DATA: begin
            if (dbus_readdatavalid) begin
               if (dbus_readdata != pattern(seed_q, b_q, k_q)) begin
                  // error_count saturates, so zero means no mismatch seen yet
                  if (err_q == '0) begin
                     ferr_d = burst_addr(b_q) + ADDR_W'(k_q) * BEAT_BYTES;
                  end
                  if (err_q != '1) begin
                     err_d = err_q + ERR_W'(1);
                  end
               end
               if (k_q == K_LAST) begin
                  k_d = '0;
                  if (b_q == B_LAST) begin
                     b_d     = '0;
                     state_d = S_DONE;
                  end else begin
                     b_d     = b_q + B_W'(1);
                     state_d = S_READ_CMD;
                  end
               end else begin
                  k_d = k_q + K_W'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_DONE) begin
         pass_d = (err_d == '0);
      end
      busy_d  = (state_d == S_WRITE) || (state_d == S_READ_CMD) || (state_d == S_READ_DATA);
      done_d  = (state_d == S_DONE);
      wr_d    = (state_d == S_WRITE);
      rd_d    = (state_d == S_READ_CMD);
      addr_d  = (wr_d || rd_d) ? burst_addr(b_d) : '0;
      wdata_d = wr_d ? pattern(seed_d, b_d, k_d) : '0;
      be_d    = (wr_d || rd_d) ? '1 : '0;
      bc_d    = (wr_d || rd_d) ? BURST_W'(BURST_LEN) : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         b_q     <= '0;
         k_q     <= '0;
         seed_q  <= '0;
         mode_q  <= '0;
         err_q   <= '0;
         ferr_q  <= '0;
         pass_q  <= 1'b0;
         perr_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         bc_q    <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         k_q     <= k_d;
         seed_q  <= seed_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
         pass_q  <= pass_d;
         perr_q  <= perr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         bc_q    <= bc_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign error_count     = err_q;
   assign first_err_addr  = ferr_q;
   assign protocol_err    = perr_q;
   assign dbus_address    = addr_q;
   assign dbus_writedata  = wdata_q;
   assign dbus_byteenable = be_q;
   assign dbus_burstcount = bc_q;
   assign dbus_read       = rd_q;
   assign dbus_write      = wr_q;

endmodule

// File: tb/tb_sdram_burst_tester.sv
// Directed bench: ideal memory slave with optional stalls and read corruption,
// checks run results and the bus sequence for sdram_burst_tester.
module tb_sdram_burst_tester;

   localparam int unsigned ADDR_W = 25;
   localparam int unsigned DATA_W = 16;

   logic                clk;
   logic                rst;
   logic                start;
   logic [1:0]          mode;
   logic [DATA_W-1:0]   seed;
   logic                busy, done, pass, protocol_err;
   logic [15:0]         error_count;
   logic [ADDR_W-1:0]   first_err_addr;
   logic [ADDR_W-1:0]   dbus_address;
   logic [DATA_W-1:0]   dbus_writedata;
   logic [DATA_W-1:0]   dbus_readdata;
   logic [1:0]          dbus_byteenable;
   logic [6:0]          dbus_burstcount;
   logic                dbus_read, dbus_write;
   logic                dbus_waitrequest, dbus_readdatavalid;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:15];
   logic [15:0] seed_run;
   bit   stall_en = 0;
   bit   inject   = 0;
   int   corrupt_idx = -1;
   int   wr_beats, wr_bad, wr_cycles, rd_cmds, rd_bad, idle_bad, done_cnt;
   int   rd_left = 0, rd_base = 0, rd_k = 0;

   sdram_burst_tester #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(7), .BURST_LEN(8),
      .NUM_BURSTS(2), .BASE_ADDR(25'h0), .ERR_W(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
      .busy(busy), .done(done), .pass(pass), .error_count(error_count),
      .first_err_addr(first_err_addr), .protocol_err(protocol_err),
      .dbus_address(dbus_address), .dbus_writedata(dbus_writedata),
      .dbus_readdata(dbus_readdata), .dbus_byteenable(dbus_byteenable),
      .dbus_burstcount(dbus_burstcount), .dbus_read(dbus_read),
      .dbus_write(dbus_write), .dbus_waitrequest(dbus_waitrequest),
      .dbus_readdatavalid(dbus_readdatavalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave model: decides inputs for the next rising edge at each falling edge
   initial begin
      dbus_waitrequest   = 1'b0;
      dbus_readdatavalid = 1'b0;
      dbus_readdata      = '0;
      forever begin
         @(negedge clk);
         dbus_readdatavalid = 1'b0;
         if (inject) begin
            dbus_readdatavalid = 1'b1;
            dbus_readdata      = 16'hDEAD;
            inject             = 0;
         end else if (rd_left > 0) begin
            dbus_readdatavalid = 1'b1;
            dbus_readdata      = mem[rd_base + rd_k] ^ ((rd_base + rd_k == corrupt_idx) ? 16'h0001 : 16'h0000);
            rd_k++;
            rd_left--;
         end
         dbus_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
         if (done === 1'b1) done_cnt++;
         if (dbus_write === 1'b1) begin
            wr_cycles++;
            if (dbus_address !== 25'((wr_beats / 8) * 16) ||
                dbus_writedata !== 16'(seed_run + 16'(wr_beats)) ||
                dbus_byteenable !== 2'b11 || dbus_burstcount !== 7'd8) wr_bad++;
            if (!dbus_waitrequest) begin
               mem[(int'(dbus_address) >> 1) + (wr_beats % 8)] = dbus_writedata;
               wr_beats++;
            end
         end else if (dbus_read === 1'b1) begin
            if (dbus_address !== 25'(rd_cmds * 16) ||
                dbus_byteenable !== 2'b11 || dbus_burstcount !== 7'd8) rd_bad++;
            if (!dbus_waitrequest) begin
               rd_cmds++;
               rd_left = 8;
               rd_base = int'(dbus_address) >> 1;
               rd_k    = 0;
            end
         end else if (dbus_byteenable !== 2'b00 || dbus_burstcount !== 7'd0) begin
            idle_bad++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clear_mon(input logic [15:0] s);
      wr_beats = 0; wr_bad = 0; wr_cycles = 0; rd_cmds = 0; rd_bad = 0;
      idle_bad = 0; done_cnt = 0; seed_run = s;
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic [15:0] s);
      clear_mon(s);
      mode  = m;
      seed  = s;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit got = 0;
      for (int i = 0; i < 3000; i++) begin
         if (done === 1'b1) begin
            got = 1;
            break;
         end
         cyc(1);
      end
      check({tag, "_done_seen"}, 32'(got), 32'd1);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; mode = 2'd0; seed = '0;
      clear_mon(16'h0);
      cyc(3);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_perr", 32'(protocol_err), 32'd0);
      check("rst_errcnt", 32'(error_count), 32'd0);
      check("rst_bus", {dbus_read, dbus_write, dbus_byteenable, dbus_burstcount}, 32'd0);
      rst = 1'b1;
      cyc(2);

      // Mode 0, ideal memory
      pulse_start(2'd0, 16'h0100);
      check("m0_busy", 32'(busy), 32'd1);
      wait_done("m0");
      check("m0_pass", 32'(pass), 32'd1);
      check("m0_errcnt", 32'(error_count), 32'd0);
      check("m0_busy_end", 32'(busy), 32'd0);
      check("m0_wr_beats", 32'(wr_beats), 32'd16);
      check("m0_wr_seq", 32'(wr_bad), 32'd0);
      check("m0_rd_cmds", 32'(rd_cmds), 32'd2);
      check("m0_rd_seq", 32'(rd_bad), 32'd0);
      check("m0_idle_bus", 32'(idle_bad), 32'd0);
      check("m0_perr", 32'(protocol_err), 32'd0);
      cyc(5);
      check("m0_done_once", 32'(done_cnt), 32'd1);
      check("m0_pass_hold", 32'(pass), 32'd1);

      // Mode 0, global word 5 corrupted on read
      corrupt_idx = 5;
      pulse_start(2'd0, 16'h0100);
      wait_done("m0c");
      check("m0c_pass", 32'(pass), 32'd0);
      check("m0c_errcnt", 32'(error_count), 32'd1);
      check("m0c_ferr", 32'(first_err_addr), 32'h0A);
      corrupt_idx = -1;
      cyc(2);

      // Mode 0 with 50% waitrequest
      stall_en = 1;
      pulse_start(2'd0, 16'h0100);
      wait_done("m0s");
      check("m0s_pass", 32'(pass), 32'd1);
      check("m0s_wr_beats", 32'(wr_beats), 32'd16);
      check("m0s_wr_seq", 32'(wr_bad), 32'd0);
      check("m0s_rd_seq", 32'(rd_bad), 32'd0);
      check("m0s_rd_cmds", 32'(rd_cmds), 32'd2);
      stall_en = 0;
      cyc(2);

      // Mode 2 check-only on preloaded memory
      for (int i = 0; i < 16; i++) mem[i] = 16'(i);
      pulse_start(2'd2, 16'h0000);
      wait_done("m2");
      check("m2_pass", 32'(pass), 32'd1);
      check("m2_no_write", 32'(wr_cycles), 32'd0);
      check("m2_rd_cmds", 32'(rd_cmds), 32'd2);
      cyc(2);
      pulse_start(2'd2, 16'h0001);
      wait_done("m2s1");
      check("m2s1_pass", 32'(pass), 32'd0);
      check("m2s1_errcnt", 32'(error_count), 32'd16);
      check("m2s1_ferr", 32'(first_err_addr), 32'h00);
      cyc(2);

      // Reset during the third write beat
      pulse_start(2'd1, 16'h0100);
      for (int i = 0; i < 50 && !(wr_beats == 2 && dbus_write === 1'b1); i++) cyc(1);
      check("rstm_third_beat", 32'(wr_beats), 32'd2);
      rst = 1'b0;
      #1;
      check("rstm_write", 32'(dbus_write), 32'd0);
      check("rstm_busy", 32'(busy), 32'd0);
      check("rstm_errcnt", 32'(error_count), 32'd0);
      cyc(2);
      rst = 1'b1;
      cyc(2);

      // Clean mode 1 run with a start pulse issued mid-run
      pulse_start(2'd1, 16'h0200);
      cyc(3);
      mode = 2'd2; start = 1'b1;
      cyc(1);
      start = 1'b0;
      wait_done("m1");
      check("m1_pass", 32'(pass), 32'd1);
      check("m1_wr_beats", 32'(wr_beats), 32'd16);
      check("m1_wr_seq", 32'(wr_bad), 32'd0);
      check("m1_no_read", 32'(rd_cmds), 32'd0);
      cyc(10);
      check("m1_done_once", 32'(done_cnt), 32'd1);
      check("m1_idle", 32'(busy), 32'd0);

      // Spurious readdatavalid while idle
      inject = 1;
      cyc(2);
      check("perr_set", 32'(protocol_err), 32'd1);
      cyc(5);
      check("perr_sticky", 32'(protocol_err), 32'd1);
      rst = 1'b0;
      #1;
      check("perr_cleared", 32'(protocol_err), 32'd0);
      cyc(1);
      rst = 1'b1;
      cyc(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
